hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard_countdown.sv | 35 +++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// hazard_scoreboard_pkg : shared load-use scoreboard definitions
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int c_ADDR_WIDTH   = 4;
  localparam int c_LOAD_LATENCY = 1;

  typedef enum logic {
    NO_STALL_PIPELINE = 1'b0,
    STALL_PIPELINE    = 1'b1
  } stall_pipeline_sig;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// hazard_scoreboard_if : EXE/DECODE bundle seen by the hazard scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int NUM_SRC    = 3,
  parameter int CNT_WIDTH  = 32
);

  logic                                mem_read_exe;
  logic                                reg_write_exe;
  logic [ADDR_WIDTH-1:0]               dest_exe;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  src_dec;
  logic [NUM_SRC-1:0]                  src_valid;
  logic                                flush;
  stall_pipeline_sig                   stall_pipeline;
  logic                                invalidate;
  logic [NUM_SRC-1:0]                  stall_src;
  logic [CNT_WIDTH-1:0]                stall_cycles;

  // Pipeline control side drives the instruction fields and consumes the stall.
  modport master (
    output mem_read_exe, reg_write_exe, dest_exe, src_dec, src_valid, flush,
    input  stall_pipeline, invalidate, stall_src, stall_cycles
  );

  modport slave (
    input  mem_read_exe, reg_write_exe, dest_exe, src_dec, src_valid, flush,
    output stall_pipeline, invalidate, stall_src, stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard_countdown.sv
// ============================================================================
// hazard_countdown : per-register in-flight load countdown
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_countdown #(
  parameter int CW = 1
) (
  input  wire logic          clk_i,
  input  wire logic          reset_n_i,
  input  wire logic          i_set,
  input  wire logic [CW-1:0] i_load_val,
  input  wire logic          i_dec,
  output logic               o_nonzero
);

  logic [CW-1:0] r_count;

  // A new load overrides any decrement in flight on the same register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (i_set) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_nonzero = |r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : load-use hazard detection with multi-cycle load latency
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int NUM_SRC      = 3,
  parameter int LOAD_LATENCY = c_LOAD_LATENCY,
  parameter int CNT_WIDTH    = 32
) (
  input  wire logic                               clk_i,
  input  wire logic                               reset_n_i,
  input  wire logic                               mem_read_EXE_i,
  input  wire logic                               reg_write_EXE_i,
  input  wire logic [ADDR_WIDTH-1:0]              dest_addr_reg_EXE_i,
  input  wire logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] source_reg_DECODE_i,
  input  wire logic [NUM_SRC-1:0]                 source_valid_DECODE_i,
  input  wire logic                               flush_i,
  output stall_pipeline_sig                       stall_pipeline_o,
  output logic                                    hazard_detector_invalidate_o,
  output logic [NUM_SRC-1:0]                      stall_src_o,
  output logic [CNT_WIDTH-1:0]                    stall_cycles_o
);

  localparam int              c_NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int              c_CW       = $clog2(LOAD_LATENCY + 1);
  localparam logic [c_CW-1:0] c_LOAD_VAL = c_CW'(LOAD_LATENCY - 1);

  logic                  w_load_live;
  logic [c_NUM_REGS-1:0] w_busy;
  logic [NUM_SRC-1:0]    w_hazard;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;

  assign w_load_live = mem_read_EXE_i && reg_write_EXE_i && !flush_i;

  generate
    for (genvar g = 0; g < c_NUM_REGS; g++) begin : g_countdown
      hazard_countdown #(
        .CW (c_CW)
      ) u_countdown (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .i_set      (w_load_live && (dest_addr_reg_EXE_i == ADDR_WIDTH'(g))),
        .i_load_val (c_LOAD_VAL),
        .i_dec      (1'b1),
        .o_nonzero  (w_busy[g])
      );
    end
  endgenerate

  // The live-EXE match covers the first stall cycle; the countdown covers the rest.
  always_comb begin
    w_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_hazard[i] = source_valid_DECODE_i[i] &&
                    ((w_load_live && (source_reg_DECODE_i[i] == dest_addr_reg_EXE_i)) ||
                     w_busy[source_reg_DECODE_i[i]]);
    end
  end

  // Reset gating keeps the combinational stall quiet while counters are held clear.
  assign stall_src_o = (flush_i || !reset_n_i) ? '0 : w_hazard;
  assign stall_pipeline_o = (|stall_src_o) ? STALL_PIPELINE : NO_STALL_PIPELINE;
  assign hazard_detector_invalidate_o = (stall_pipeline_o == STALL_PIPELINE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cycles <= '0;
    end else if ((stall_pipeline_o == STALL_PIPELINE) && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o = r_stall_cycles;

endmodule

`default_nettype wire
